// File: rtl/fifo_peek_serializer.sv
// Serialises DataWidth-bit words peeked from an upstream FIFO head into OutWidth-bit slices, LSB slice first.
// Optional completed-word counter: define FIFO_PEEK_SERIALIZER_COUNT_EN to add the WordCount port.
module fifo_peek_serializer #(
  parameter int DataWidth = 32,
  parameter int OutWidth  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 PeekValid,
  input  logic [DataWidth-1:0] PeekData,
  output logic                 Deq,
  output logic                 StreamValid,
  output logic [OutWidth-1:0]  StreamData,
  output logic                 StreamLast,
  input  logic                 StreamReady
`ifdef FIFO_PEEK_SERIALIZER_COUNT_EN
  ,
  output logic [15:0]          WordCount
`endif
);

  localparam int Ratio = DataWidth / OutWidth;
  localparam int CntW  = (Ratio > 1) ? $clog2(Ratio) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(Ratio - 1);

  if ((DataWidth % OutWidth) != 0 || Ratio < 1) begin : gRatioCheck
    $error("fifo_peek_serializer: DataWidth must be a positive multiple of OutWidth");
  end

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t               stateReg, stateNext;
  logic [DataWidth-1:0] shiftReg, shiftNext, shiftedWord;
  logic [CntW-1:0]      cntReg, cntNext;

  // Each slice moves down one position; the vacated top slice fills with zeros.
  for (genvar gi = 0; gi < Ratio; gi++) begin : gSlice
    if (gi < Ratio - 1) begin : gMove
      assign shiftedWord[gi*OutWidth +: OutWidth] = shiftReg[(gi+1)*OutWidth +: OutWidth];
    end else begin : gFill
      assign shiftedWord[gi*OutWidth +: OutWidth] = '0;
    end
  end

  assign StreamValid = (stateReg == SHIFT);
  assign StreamData  = shiftReg[OutWidth-1:0];
  assign StreamLast  = (stateReg == SHIFT) && (cntReg == LastIdx);

  always_comb begin
    stateNext = stateReg;
    shiftNext = shiftReg;
    cntNext   = cntReg;
    // Reset gates Deq so a word is never consumed while the pipeline is being cleared.
    Deq = !rst && PeekValid && ((stateReg == IDLE) || (StreamReady && StreamLast));
    if (Deq) begin
      shiftNext = PeekData;
      cntNext   = '0;
      stateNext = SHIFT;
    end else if ((stateReg == SHIFT) && StreamReady) begin
      if (StreamLast) begin
        stateNext = IDLE;
      end else begin
        shiftNext = shiftedWord;
        cntNext   = cntReg + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateReg <= IDLE;
      shiftReg <= '0;
      cntReg   <= '0;
    end else begin
      stateReg <= stateNext;
      shiftReg <= shiftNext;
      cntReg   <= cntNext;
    end
  end

`ifdef FIFO_PEEK_SERIALIZER_COUNT_EN
  logic [15:0] wordCountReg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wordCountReg <= '0;
    end else if (StreamLast && StreamReady) begin
      wordCountReg <= wordCountReg + 16'd1;
    end
  end

  assign WordCount = wordCountReg;
`endif

endmodule

// File: tb/tb_fifo_peek_serializer.sv
// Directed bench for fifo_peek_serializer: a 32/8 instance and an 8/8 (single-slice) instance.
module tb_fifo_peek_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic        PeekValid;
  logic [31:0] PeekData;
  logic        Deq;
  logic        StreamValid;
  logic [7:0]  StreamData;
  logic        StreamLast;
  logic        StreamReady;

  logic        r1PeekValid;
  logic [7:0]  r1PeekData;
  logic        r1Deq;
  logic        r1StreamValid;
  logic [7:0]  r1StreamData;
  logic        r1StreamLast;
  logic        r1StreamReady;

`ifdef FIFO_PEEK_SERIALIZER_COUNT_EN
  logic [15:0] WordCount;
  logic [15:0] r1WordCount;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_peek_serializer #(.DataWidth(32), .OutWidth(8)) dut (
    .clk(clk), .rst(rst), .PeekValid(PeekValid), .PeekData(PeekData), .Deq(Deq),
    .StreamValid(StreamValid), .StreamData(StreamData), .StreamLast(StreamLast),
    .StreamReady(StreamReady)
`ifdef FIFO_PEEK_SERIALIZER_COUNT_EN
    , .WordCount(WordCount)
`endif
  );

  fifo_peek_serializer #(.DataWidth(8), .OutWidth(8)) dutR1 (
    .clk(clk), .rst(rst), .PeekValid(r1PeekValid), .PeekData(r1PeekData), .Deq(r1Deq),
    .StreamValid(r1StreamValid), .StreamData(r1StreamData), .StreamLast(r1StreamLast),
    .StreamReady(r1StreamReady)
`ifdef FIFO_PEEK_SERIALIZER_COUNT_EN
    , .WordCount(r1WordCount)
`endif
  );

  // Stimulus only: present one word, then stream it out with StreamReady held high.
  task automatic send_word(input logic [31:0] w);
    @(negedge clk);
    PeekValid = 1'b1; PeekData = w; StreamReady = 1'b1;
    @(negedge clk);
    PeekValid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    PeekValid = 1'b1; PeekData = 32'h12345678; StreamReady = 1'b1;
    r1PeekValid = 1'b0; r1PeekData = 8'h00; r1StreamReady = 1'b1;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (StreamValid !== 1'b0 || StreamLast !== 1'b0 || Deq !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs valid=%b last=%b deq=%b required 0 0 0", StreamValid, StreamLast, Deq);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    PeekValid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (StreamValid !== 1'b0 || StreamData !== 8'h00) begin
      failures++;
      $display("FAIL reset_data valid=%b data=%h required 0 00", StreamValid, StreamData);
    end
    $display("reset done");
  endtask

  task automatic test_single_word();
    logic [7:0] exp [4];
    exp[0] = 8'h11; exp[1] = 8'h22; exp[2] = 8'h33; exp[3] = 8'h44;
    @(negedge clk);
    PeekValid = 1'b1; PeekData = 32'h44332211; StreamReady = 1'b1;
    #1;
    checks++;
    if (Deq !== 1'b1 || StreamValid !== 1'b0) begin
      failures++;
      $display("FAIL single_deq deq=%b valid=%b required 1 0", Deq, StreamValid);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      PeekValid = 1'b0;
      #1;
      checks++;
      if (StreamValid !== 1'b1 || StreamData !== exp[i] || StreamLast !== (i == 3) || Deq !== 1'b0) begin
        failures++;
        $display("FAIL single_slice%0d valid=%b data=%h last=%b deq=%b required 1 %h %b 0",
                 i, StreamValid, StreamData, StreamLast, Deq, exp[i], (i == 3));
      end
      $display("single slice %0d data=%h last=%b", i, StreamData, StreamLast);
    end
    @(negedge clk);
    #1;
    checks++;
    if (StreamValid !== 1'b0) begin
      failures++;
      $display("FAIL single_idle valid=%b required 0", StreamValid);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [8];
    exp[0] = 8'hA0; exp[1] = 8'hA1; exp[2] = 8'hA2; exp[3] = 8'hA3;
    exp[4] = 8'hB0; exp[5] = 8'hB1; exp[6] = 8'hB2; exp[7] = 8'hB3;
    @(negedge clk);
    PeekValid = 1'b1; PeekData = 32'hA3A2A1A0; StreamReady = 1'b1;
    #1;
    checks++;
    if (Deq !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first_deq deq=%b required 1", Deq);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      PeekValid = (i < 4);
      PeekData  = 32'hB3B2B1B0;
      #1;
      checks++;
      if (StreamValid !== 1'b1 || StreamData !== exp[i] || StreamLast !== (i % 4 == 3) ||
          Deq !== (i == 3)) begin
        failures++;
        $display("FAIL b2b_slice%0d valid=%b data=%h last=%b deq=%b required 1 %h %b %b",
                 i, StreamValid, StreamData, StreamLast, Deq, exp[i], (i % 4 == 3), (i == 3));
      end
      $display("b2b slice %0d data=%h last=%b deq=%b", i, StreamData, StreamLast, Deq);
    end
    @(negedge clk);
    #1;
    checks++;
    if (StreamValid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle valid=%b required 0", StreamValid);
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    PeekValid = 1'b1; PeekData = 32'h44332211; StreamReady = 1'b1;
    @(negedge clk);
    PeekValid = 1'b0;
    @(negedge clk);
    // Slice 0x22 now showing; stall with a new head word pending.
    StreamReady = 1'b0; PeekValid = 1'b1; PeekData = 32'hDEADDEAD;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (StreamValid !== 1'b1 || StreamData !== 8'h22 || StreamLast !== 1'b0 || Deq !== 1'b0) begin
        failures++;
        $display("FAIL stall%0d valid=%b data=%h last=%b deq=%b required 1 22 0 0",
                 i, StreamValid, StreamData, StreamLast, Deq);
      end
      $display("stall cycle %0d data=%h", i, StreamData);
      @(negedge clk);
    end
    PeekValid = 1'b0; StreamReady = 1'b1;
    #1;
    checks++;
    if (StreamData !== 8'h22) begin
      failures++;
      $display("FAIL stall_release data=%h required 22", StreamData);
    end
    @(negedge clk);
    #1;
    checks++;
    if (StreamData !== 8'h33 || StreamLast !== 1'b0) begin
      failures++;
      $display("FAIL stall_next data=%h last=%b required 33 0", StreamData, StreamLast);
    end
    @(negedge clk);
    #1;
    checks++;
    if (StreamData !== 8'h44 || StreamLast !== 1'b1) begin
      failures++;
      $display("FAIL stall_last data=%h last=%b required 44 1", StreamData, StreamLast);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] exp [4];
    exp[0] = 8'hEF; exp[1] = 8'hBE; exp[2] = 8'h00; exp[3] = 8'h00;
    @(negedge clk);
    PeekValid = 1'b1; PeekData = 32'h44332211; StreamReady = 1'b1;
    @(negedge clk);
    PeekValid = 1'b0;
    repeat (2) @(negedge clk);
    PeekValid = 1'b1; PeekData = 32'h0000BEEF;
    rst = 1'b1;
    #1;
    checks++;
    if (StreamValid !== 1'b0 || Deq !== 1'b0) begin
      failures++;
      $display("FAIL midreset valid=%b deq=%b required 0 0", StreamValid, Deq);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (Deq !== 1'b1 || StreamValid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_idle deq=%b valid=%b required 1 0", Deq, StreamValid);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      PeekValid = 1'b0;
      #1;
      checks++;
      if (StreamValid !== 1'b1 || StreamData !== exp[i] || StreamLast !== (i == 3)) begin
        failures++;
        $display("FAIL midreset_slice%0d data=%h last=%b required %h %b",
                 i, StreamData, StreamLast, exp[i], (i == 3));
      end
      $display("post-reset slice %0d data=%h", i, StreamData);
    end
    @(negedge clk);
  endtask

  task automatic test_ratio_one();
    int deqCount = 0;
    @(negedge clk);
    r1PeekValid = 1'b1; r1PeekData = 8'h5A; r1StreamReady = 1'b1;
    #1;
    if (r1Deq === 1'b1) deqCount++;
    checks++;
    if (r1Deq !== 1'b1 || r1StreamValid !== 1'b0) begin
      failures++;
      $display("FAIL r1_load deq=%b valid=%b required 1 0", r1Deq, r1StreamValid);
    end
    @(negedge clk);
    r1PeekData = 8'hC3;
    #1;
    if (r1Deq === 1'b1) deqCount++;
    checks++;
    if (r1StreamValid !== 1'b1 || r1StreamData !== 8'h5A || r1StreamLast !== 1'b1 || r1Deq !== 1'b1) begin
      failures++;
      $display("FAIL r1_slice0 valid=%b data=%h last=%b deq=%b required 1 5a 1 1",
               r1StreamValid, r1StreamData, r1StreamLast, r1Deq);
    end
    @(negedge clk);
    r1PeekValid = 1'b0;
    #1;
    if (r1Deq === 1'b1) deqCount++;
    checks++;
    if (r1StreamValid !== 1'b1 || r1StreamData !== 8'hC3 || r1StreamLast !== 1'b1 || r1Deq !== 1'b0) begin
      failures++;
      $display("FAIL r1_slice1 valid=%b data=%h last=%b deq=%b required 1 c3 1 0",
               r1StreamValid, r1StreamData, r1StreamLast, r1Deq);
    end
    @(negedge clk);
    #1;
    checks++;
    if (r1StreamValid !== 1'b0 || deqCount != 2) begin
      failures++;
      $display("FAIL r1_end valid=%b deqs=%0d required 0 2", r1StreamValid, deqCount);
    end
    $display("ratio-one words done deqs=%0d", deqCount);
  endtask

`ifdef FIFO_PEEK_SERIALIZER_COUNT_EN
  task automatic test_word_count();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send_word(32'h01020304);
    send_word(32'h05060708);
    send_word(32'h090A0B0C);
    @(negedge clk);
    #1;
    checks++;
    if (WordCount !== 16'd3) begin
      failures++;
      $display("FAIL count_three count=%0d required 3", WordCount);
    end
    dut.wordCountReg = 16'hFFFF;
    send_word(32'h11111111);
    @(negedge clk);
    #1;
    checks++;
    if (WordCount !== 16'h0000) begin
      failures++;
      $display("FAIL count_wrap count=%h required 0000", WordCount);
    end
    $display("word count wrap count=%h", WordCount);
  endtask
`endif

  initial begin
    fork
      begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_word();
        test_ratio_one();
`ifdef FIFO_PEEK_SERIALIZER_COUNT_EN
        test_word_count();
`endif
      end
      begin
        #50000;
        failures++;
        $display("FAIL timeout simulation exceeded 50000 time units");
      end
    join_any
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
